xc_packetizer: RTL and testbench

XC_PACKETIZER -- requirements
Module: xc_packetizer

---
 rtl/xc_packetizer.sv | 210 +++++++++++++++++++++
 tb/tb_xc_packetizer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xc_packetizer.sv
// xc_packetizer: snapshots a correlator accumulator bus plus a 64-bit timestamp and streams
// them out as a framed packet, one symbol per tx_valid/tx_ready handshake.
//
// Packet layout, each field sent MSB nibble first:
//   header  : 64-bit timestamp latched at capture
//   payload : words NUM_WORDS-1 down to 0, RESOLUTION bits each
//   footer  : {seq[15:0], 16'h0000, checksum[31:0]}, checksum = XOR of all payload words
//   term    : 0x0D, sent only in ASCII mode
// BINARY=0 sends one ASCII hex character per nibble; BINARY=1 sends one raw byte per two nibbles.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   enable        permits new snapshots when idle
//   snapshot_req  request to capture and send one packet
//   data_in       accumulator bus, word k at [k*RESOLUTION +: RESOLUTION]
//   timestamp     free-running time count
//   tx_data       output symbol
//   tx_valid      tx_data is valid
//   tx_ready      downstream accepts the symbol
//   busy          a packet is in progress
//   clear_acc     one-cycle pulse, the cycle after capture, to zero the accumulators
//   overflow      sticky: a snapshot request arrived while busy; cleared at the next capture

module xc_packetizer #(
    parameter int unsigned NUM_WORDS  = 2,
    parameter int unsigned RESOLUTION = 24,
    parameter bit          BINARY     = 1'b0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            snapshot_req,
    input  logic [NUM_WORDS*RESOLUTION-1:0] data_in,
    input  logic [63:0]                     timestamp,
    output logic [7:0]                      tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic                            busy,
    output logic                            clear_acc,
    output logic                            overflow
);

    localparam int unsigned DataW    = NUM_WORDS * RESOLUTION;
    localparam int unsigned SymBits  = BINARY ? 8 : 4;
    localparam int unsigned SecSyms  = 64 / SymBits;         // symbols in header and footer
    localparam int unsigned WordSyms = RESOLUTION / SymBits; // symbols per payload word
    localparam int unsigned SymW     = 5;                    // holds up to 16 symbols
    localparam int unsigned WordW    = 12;                   // word index for up to 4096 words

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StPayload,
        StFooter,
        StTerm
    } state_e;

    state_e               state_q, state_d;
    logic [63:0]          ts_q, ts_d;
    logic [DataW-1:0]     data_q, data_d;
    logic [SymW-1:0]      sym_q, sym_d;
    logic [WordW-1:0]     word_q, word_d;
    logic [31:0]          chk_q, chk_d;
    logic [15:0]          seq_q, seq_d;
    logic                 ovf_q, ovf_d;
    logic                 clr_q, clr_d;

    logic                 xfer;
    logic [RESOLUTION-1:0] word_sel;
    logic [31:0]          word_ext;
    logic [63:0]          sec;
    logic [63:0]          sec_sh;

    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        // 0x37 + 10 = 'A'
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign tx_valid  = (state_q != StIdle);
    assign busy      = (state_q != StIdle);
    assign clear_acc = clr_q;
    assign overflow  = ovf_q;
    assign xfer      = tx_valid && tx_ready;

    // Current field left-justified in a 64-bit window, then shifted so the symbol being
    // presented sits in the top bits. Everything comes from registers, so tx_data holds
    // steady while stalled.
    always_comb begin
        word_sel = data_q[int'(word_q)*RESOLUTION +: RESOLUTION];
        word_ext = 32'(word_sel);
        case (state_q)
            StHeader:  sec = ts_q;
            StPayload: sec = {word_ext << (32 - RESOLUTION), 32'h0};
            StFooter:  sec = {seq_q, 16'h0000, chk_q};
            default:   sec = 64'h0;
        endcase
        sec_sh = sec << (SymBits * sym_q);

        tx_data = 8'h00;
        if (state_q == StTerm) begin
            tx_data = 8'h0D;
        end else if (state_q != StIdle) begin
            tx_data = BINARY ? sec_sh[63:56] : to_ascii(sec_sh[63:60]);
        end
    end

    always_comb begin
        state_d = state_q;
        ts_d    = ts_q;
        data_d  = data_q;
        sym_d   = sym_q;
        word_d  = word_q;
        chk_d   = chk_q;
        seq_d   = seq_q;
        ovf_d   = ovf_q;
        clr_d   = 1'b0;

        // Requests while busy are dropped, including on the final-symbol cycle.
        if (state_q != StIdle && snapshot_req) begin
            ovf_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (snapshot_req && enable) begin
                    ts_d    = timestamp;
                    data_d  = data_in;
                    chk_d   = 32'h0;
                    ovf_d   = 1'b0;
                    sym_d   = '0;
                    word_d  = WordW'(NUM_WORDS - 1);
                    clr_d   = 1'b1;
                    state_d = StHeader;
                end
            end
            StHeader: begin
                if (xfer) begin
                    if (sym_q == SymW'(SecSyms - 1)) begin
                        sym_d   = '0;
                        state_d = StPayload;
                    end else begin
                        sym_d = sym_q + 1'b1;
                    end
                end
            end
            StPayload: begin
                if (xfer) begin
                    if (sym_q == SymW'(WordSyms - 1)) begin
                        chk_d = chk_q ^ word_ext;
                        sym_d = '0;
                        if (word_q == '0) begin
                            state_d = StFooter;
                        end else begin
                            word_d = word_q - 1'b1;
                        end
                    end else begin
                        sym_d = sym_q + 1'b1;
                    end
                end
            end
            StFooter: begin
                if (xfer) begin
                    if (sym_q == SymW'(SecSyms - 1)) begin
                        sym_d = '0;
                        if (BINARY) begin
                            seq_d   = seq_q + 16'd1;
                            state_d = StIdle;
                        end else begin
                            state_d = StTerm;
                        end
                    end else begin
                        sym_d = sym_q + 1'b1;
                    end
                end
            end
            StTerm: begin
                if (xfer) begin
                    seq_d   = seq_q + 16'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ts_q    <= 64'h0;
            data_q  <= '0;
            sym_q   <= '0;
            word_q  <= '0;
            chk_q   <= 32'h0;
            seq_q   <= 16'h0;
            ovf_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            data_q  <= data_d;
            sym_q   <= sym_d;
            word_q  <= word_d;
            chk_q   <= chk_d;
            seq_q   <= seq_d;
            ovf_q   <= ovf_d;
            clr_q   <= clr_d;
        end
    end

endmodule

// File: tb/tb_xc_packetizer.sv
// Bench for xc_packetizer: an ASCII instance and a binary instance (NUM_WORDS=2,
// RESOLUTION=8) share stimulus; streams are collected on the falling edge and compared
// against hand-written packets.

module tb_xc_packetizer;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        snapshot_req;
    logic [15:0] data_in;
    logic [63:0] timestamp;
    logic        tx_ready;

    logic [7:0]  a_data, b_data;
    logic        a_valid, b_valid, a_busy, b_busy, a_clr, b_clr, a_ovf, b_ovf;

    int checks = 0;
    int errors = 0;

    bq_t  qa, qb;
    int   clr_a, clr_b;
    bit   a_stall, b_stall;
    logic [7:0] a_prev, b_prev;

    always #5 clk = ~clk;

    xc_packetizer #(.NUM_WORDS(2), .RESOLUTION(8), .BINARY(1'b0)) u_ascii (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .snapshot_req (snapshot_req),
        .data_in      (data_in),
        .timestamp    (timestamp),
        .tx_data      (a_data),
        .tx_valid     (a_valid),
        .tx_ready     (tx_ready),
        .busy         (a_busy),
        .clear_acc    (a_clr),
        .overflow     (a_ovf)
    );

    xc_packetizer #(.NUM_WORDS(2), .RESOLUTION(8), .BINARY(1'b1)) u_bin (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .snapshot_req (snapshot_req),
        .data_in      (data_in),
        .timestamp    (timestamp),
        .tx_data      (b_data),
        .tx_valid     (b_valid),
        .tx_ready     (tx_ready),
        .busy         (b_busy),
        .clear_acc    (b_clr),
        .overflow     (b_ovf)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] hexval(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return 4'(c - 8'h30);
        return 4'(c - 8'h37);
    endfunction

    function automatic bq_t mk_ascii(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        q.push_back(8'h0D);
        return q;
    endfunction

    function automatic bq_t mk_bin(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i += 2) q.push_back({hexval(s[i]), hexval(s[i+1])});
        return q;
    endfunction

    task automatic cmp_stream(input string tag, input bq_t got, input bq_t exp);
        check_eq({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) check_eq($sformatf("%s[%0d]", tag, i), {56'h0, got[i]},
                                         {56'h0, exp[i]});
        end
    endtask

    // Collect transferred symbols; a stalled symbol must still be presented, unchanged,
    // on the next cycle.
    always @(negedge clk) begin
        if (reset) begin
            a_stall = 1'b0;
            b_stall = 1'b0;
        end else begin
            if (a_stall) begin
                check_eq("stall_data_a", {56'h0, a_data}, {56'h0, a_prev});
                check_eq("stall_valid_a", {63'h0, a_valid}, 64'h1);
            end
            if (b_stall) begin
                check_eq("stall_data_b", {56'h0, b_data}, {56'h0, b_prev});
                check_eq("stall_valid_b", {63'h0, b_valid}, 64'h1);
            end
            if (a_valid && tx_ready) qa.push_back(a_data);
            if (b_valid && tx_ready) qb.push_back(b_data);
            a_stall = a_valid && !tx_ready;
            b_stall = b_valid && !tx_ready;
            a_prev  = a_data;
            b_prev  = b_data;
            if (a_clr) clr_a++;
            if (b_clr) clr_b++;
        end
    end

    task automatic start_pkt();
        qa.delete();
        qb.delete();
        clr_a = 0;
        clr_b = 0;
        snapshot_req = 1'b1;
        @(posedge clk);
        #1 snapshot_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit random_ready);
        int n = 0;
        while ((a_busy || b_busy) && n < budget) begin
            @(posedge clk);
            #1;
            if (random_ready) tx_ready = 1'($urandom_range(0, 1));
            n++;
        end
        tx_ready = 1'b1;
        check_eq("done_idle", {62'h0, a_busy, b_busy}, 64'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        snapshot_req = 1'b0;
        tx_ready     = 1'b1;
        data_in      = 16'hA51F;
        timestamp    = 64'h12;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_valid", {62'h0, a_valid, b_valid}, 64'h0);
        check_eq("rst_busy", {62'h0, a_busy, b_busy}, 64'h0);
        check_eq("rst_clr", {62'h0, a_clr, b_clr}, 64'h0);
        check_eq("rst_ovf", {62'h0, a_ovf, b_ovf}, 64'h0);
        check_eq("rst_data", {48'h0, a_data, b_data}, 64'h0);

        // Packet 1: plain stream; data_in changes right after capture
        @(posedge clk);
        #1 enable = 1'b1;
        start_pkt();
        data_in = 16'h5555;
        @(negedge clk);
        check_eq("p1_valid_lat", {62'h0, a_valid, b_valid}, 64'h3);
        check_eq("p1_clr_on", {62'h0, a_clr, b_clr}, 64'h3);
        check_eq("p1_busy", {62'h0, a_busy, b_busy}, 64'h3);
        @(negedge clk);
        check_eq("p1_clr_off", {62'h0, a_clr, b_clr}, 64'h0);
        wait_idle(200, 1'b0);
        cmp_stream("p1_a", qa, mk_ascii("0000000000000012A51F00000000000000BA"));
        cmp_stream("p1_b", qb, mk_bin("0000000000000012A51F00000000000000BA"));
        check_eq("p1_clr_cnt", {32'(clr_a), 32'(clr_b)}, {32'd1, 32'd1});

        // Packet 2: request mid-packet sets overflow; enable dropped mid-packet
        data_in = 16'hA51F;
        start_pkt();
        repeat (5) @(posedge clk);
        #1 snapshot_req = 1'b1;
        @(posedge clk);
        #1 snapshot_req = 1'b0;
        @(negedge clk);
        check_eq("p2_ovf_set", {62'h0, a_ovf, b_ovf}, 64'h3);
        @(posedge clk);
        #1 enable = 1'b0;
        wait_idle(200, 1'b0);
        cmp_stream("p2_a", qa, mk_ascii("0000000000000012A51F00010000000000BA"));
        cmp_stream("p2_b", qb, mk_bin("0000000000000012A51F00010000000000BA"));
        check_eq("p2_clr_cnt", {32'(clr_a), 32'(clr_b)}, {32'd1, 32'd1});
        check_eq("p2_ovf_sticky", {62'h0, a_ovf, b_ovf}, 64'h3);

        // Packet 3: random backpressure; overflow cleared at capture
        enable    = 1'b1;
        data_in   = 16'h0FF0;
        timestamp = 64'hFEDCBA9876543210;
        start_pkt();
        data_in = 16'hFFFF;
        @(negedge clk);
        check_eq("p3_ovf_clr", {62'h0, a_ovf, b_ovf}, 64'h0);
        wait_idle(800, 1'b1);
        cmp_stream("p3_a", qa, mk_ascii("FEDCBA98765432100FF000020000000000FF"));
        cmp_stream("p3_b", qb, mk_bin("FEDCBA98765432100FF000020000000000FF"));

        // Packet 4: reset while payload symbol 2 is presented
        data_in = 16'h1234;
        start_pkt();
        for (int n = 0; n < 100 && qa.size() < 18; n++) begin
            @(posedge clk);
            #1;
        end
        check_eq("p4_reached", 64'(qa.size()), 64'd18);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("p4_valid", {62'h0, a_valid, b_valid}, 64'h0);
        check_eq("p4_busy", {62'h0, a_busy, b_busy}, 64'h0);
        check_eq("p4_clr", {62'h0, a_clr, b_clr}, 64'h0);
        check_eq("p4_data", {48'h0, a_data, b_data}, 64'h0);
        qa.delete();
        qb.delete();
        repeat (5) @(posedge clk);
        #1;
        check_eq("p4_silent", 64'(qa.size() + qb.size()), 64'd0);

        // Enable gating: request in idle with enable=0 is ignored, no overflow
        enable = 1'b0;
        start_pkt();
        @(negedge clk);
        check_eq("gate_busy", {62'h0, a_busy, b_busy}, 64'h0);
        check_eq("gate_ovf", {62'h0, a_ovf, b_ovf}, 64'h0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("gate_silent", 64'(qa.size() + qb.size()), 64'd0);

        // Packet 5: after reset, seq restarts and checksum is fresh
        enable    = 1'b1;
        data_in   = 16'h3C7E;
        timestamp = 64'h0123456789ABCDEF;
        start_pkt();
        wait_idle(200, 1'b0);
        cmp_stream("p5_a", qa, mk_ascii("0123456789ABCDEF3C7E0000000000000042"));
        cmp_stream("p5_b", qb, mk_bin("0123456789ABCDEF3C7E0000000000000042"));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
